// File: rtl/mcca_pkg.sv
// Shared types and constants for the MCCA adder scheduler.
// Imported by the scheduler top and its arbiter.
package mcca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    EVAL,
    DONE
  } state_e;

  localparam int SIZE_DEF   = 16;
  localparam int CHUNKS_DEF = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcca_add_scheduler_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// ptr names the requester that wins when both are valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       gid
);

  always_comb begin
    gid   = 1'b0;
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b11): gid = ptr;
      (valid == 2'b10): gid = 1'b1;
      default:          gid = 1'b0;
    endcase
    if (|valid) grant = gid ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mcca_add_scheduler.sv
// Time-shares one SIZE-bit Manchester carry-chain core between two
// requesters, running WIDTH-bit adds one chunk per precharge/evaluate pair.
module mcca_add_scheduler
  import mcca_pkg::*;
#(
  parameter  int SIZE   = SIZE_DEF,
  parameter  int CHUNKS = CHUNKS_DEF,
  localparam int WIDTH  = SIZE * CHUNKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             add_pc,
  output logic [SIZE-1:0]  add_a,
  output logic [SIZE-1:0]  add_b,
  output logic             add_cin,
  input  logic [SIZE-1:0]  add_sum,
  input  logic             add_cout,
  output logic             busy
);

  localparam int IW = idx_w(CHUNKS);
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic [SIZE-1:0]  add_a_q, add_a_d;
  logic [SIZE-1:0]  add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;

  logic [1:0] valid;
  logic [1:0] grant;
  logic       gid;

  assign valid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .valid(valid),
    .ptr  (rr_q),
    .grant(grant),
    .gid  (gid)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    id_d       = id_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|valid) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          a_d        = gid ? req1_a : req0_a;
          b_d        = gid ? req1_b : req0_b;
          carry_d    = gid ? req1_cin : req0_cin;
          id_d       = gid;
          idx_d      = '0;
          add_a_d    = a_d[SIZE-1:0];
          add_b_d    = b_d[SIZE-1:0];
          add_cin_d  = carry_d;
          state_d    = PRE;
        end
      end
      PRE: state_d = EVAL;
      EVAL: begin
        sum_d[int'(idx_q)*SIZE +: SIZE] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d     = idx_q + 1'b1;
          add_a_d   = a_q[int'(idx_d)*SIZE +: SIZE];
          add_b_d   = b_q[int'(idx_d)*SIZE +: SIZE];
          add_cin_d = add_cout;
          state_d   = PRE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          rr_d    = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      id_q      <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      id_q      <= id_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
    end
  end

  // Decoded straight from state so reset forces precharge with no clock.
  assign add_pc     = (state_q != EVAL);
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_cin    = add_cin_q;
  assign resp_valid = (state_q == DONE);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = carry_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mcca_add_scheduler.sv
// Directed bench for mcca_add_scheduler with a behavioural MCC core.
// Core output is junk while precharging so early sampling shows up.
module tb_mcca_add_scheduler;

  localparam int SIZE   = 16;
  localparam int CHUNKS = 4;
  localparam int WIDTH  = SIZE * CHUNKS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a = '0;
  logic [WIDTH-1:0] req0_b = '0;
  logic             req0_cin = 1'b0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a = '0;
  logic [WIDTH-1:0] req1_b = '0;
  logic             req1_cin = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic             resp_id;
  logic [WIDTH-1:0] resp_sum;
  logic             resp_cout;
  logic             add_pc;
  logic [SIZE-1:0]  add_a;
  logic [SIZE-1:0]  add_b;
  logic             add_cin;
  logic [SIZE-1:0]  add_sum;
  logic             add_cout;
  logic             busy;

  int n_run  = 0;
  int n_fail = 0;

  mcca_add_scheduler #(.SIZE(SIZE), .CHUNKS(CHUNKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_cin  (req0_cin),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_cin  (req1_cin),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_sum  (resp_sum),
    .resp_cout (resp_cout),
    .add_pc    (add_pc),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [SIZE:0] core_r;
  assign core_r   = {1'b0, add_a} + {1'b0, add_b} + {{SIZE{1'b0}}, add_cin};
  assign add_sum  = add_pc ? ~add_a : core_r[SIZE-1:0];
  assign add_cout = add_pc ? ~core_r[SIZE] : core_r[SIZE];

  int              pc_total = 0;
  int              stab_err = 0;
  logic [SIZE-1:0] pa = '0;
  logic [SIZE-1:0] pb = '0;
  logic            pcin = 1'b0;

  always @(negedge clk) begin
    if (rst_n && !add_pc) begin
      pc_total <= pc_total + 1;
      if ({pa, pb, pcin} !== {add_a, add_b, add_cin}) stab_err <= stab_err + 1;
    end
    pa   <= add_a;
    pb   <= add_b;
    pcin <= add_cin;
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input bit exp_id, input logic [WIDTH-1:0] exp_sum,
                     input logic exp_cout, input bit drop);
    int t;
    int lat;
    int pc0;
    int se0;
    bit who;
    t = 0;
    #1;
    while (!(req0_ready || req1_ready) && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!(req0_ready || req1_ready)) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    who = req1_ready;
    chk("grant_id", who, exp_id);
    chk("ready_onehot", req0_ready & req1_ready, 0);
    pc0 = pc_total;
    se0 = stab_err;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (drop && lat == 1) begin
        if (who) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
      end
    end while (!resp_valid && lat < 40);
    chk("latency", lat, 9);
    chk("resp_sum", resp_sum, exp_sum);
    chk("resp_cout", resp_cout, exp_cout);
    chk("resp_id", resp_id, exp_id);
    chk("pc_low_cycles", pc_total - pc0, 4);
    chk("core_in_stable", stab_err - se0, 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nresp;
    logic [WIDTH-1:0] held;
    #1;
    chk("rst_add_pc", add_pc, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_core_in", {add_a, add_b, add_cin}, 0);
    chk("rst_resp", {resp_id, resp_cout, resp_sum}, 0);
    reset_dut();

    // 1: single chunk carry into chunk 1
    req0_a = 64'h0000_0000_0000_FFFF; req0_b = 64'h1; req0_cin = 1'b0;
    req0_valid = 1'b1;
    run(1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b1);

    // 2: carry ripples across every chunk
    @(negedge clk);
    req1_a = '1; req1_b = '0; req1_cin = 1'b1;
    req1_valid = 1'b1;
    run(1'b1, 64'h0, 1'b1, 1'b1);

    // 3: both continuously valid after reset
    @(negedge clk);
    reset_dut();
    req0_a = 64'h0123_4567_89AB_CDEF; req0_b = 64'h1111_1111_1111_1111;
    req0_cin = 1'b0;
    req1_a = 64'h8000_0000_0000_0000; req1_b = 64'h8000_0000_0000_0001;
    req1_cin = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    run(1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);
    run(1'b1, 64'h0000_0000_0000_0002, 1'b1, 1'b0);
    run(1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);
    run(1'b1, 64'h0000_0000_0000_0002, 1'b1, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // 4: back-pressure in DONE with a pending request
    @(negedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req0_a = 64'h0000_FFFF_0000_FFFF; req0_b = 64'h0000_0001_0000_0001;
    req0_cin = 1'b0;
    req0_valid = 1'b1;
    run(1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b1);
    req1_a = 64'hDEAD_BEEF_0000_0000; req1_b = 64'h0000_0000_CAFE_F00D;
    req1_cin = 1'b0;
    req1_valid = 1'b1;
    held = resp_sum;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_sum", resp_sum, held);
      chk("hold_id", resp_id, 0);
      chk("hold_ready", {req0_ready, req1_ready}, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("pending_accept", req1_ready, 1);
    run(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);

    // 5: reset during EVAL of chunk 2
    @(negedge clk);
    req0_a = 64'hAAAA_5555_AAAA_5555; req0_b = 64'h1234_1234_1234_1234;
    req0_cin = 1'b1;
    req0_valid = 1'b1;
    #1;
    chk("pre_reset_accept", req0_ready, 1);
    repeat (6) begin
      @(negedge clk);
      req0_valid = 1'b0;
    end
    #1;
    chk("eval_before_reset", add_pc, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_add_pc", add_pc, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_core_in", {add_a, add_b, add_cin}, 0);
    chk("mid_rst_resp", {resp_id, resp_cout, resp_sum}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nresp = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("no_resp_after_abort", nresp, 0);
    req0_a = 64'h3; req0_b = 64'h5; req0_cin = 1'b0;
    req0_valid = 1'b1;
    run(1'b0, 64'h8, 1'b0, 1'b1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1);
  end

endmodule
